// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU memory bus: OAM DMA states, bus owner codes
// and the fixed NES register addresses used by the arbiter.
package cpu_bus_pkg;

    localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
    localparam int          DMA_LEN      = 256;
    localparam int          CNT_W        = $clog2(DMA_LEN);

    typedef enum logic [2:0] {
        IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_RD,
        DMA_WR
    } dma_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_F,
        OWN_E,
        OWN_DMA
    } bus_owner_t;

    function automatic logic is_dma_trigger(input logic        gnt,
                                            input logic        rw_n,
                                            input logic [15:0] addr);
        return gnt & ~rw_n & (addr == OAM_DMA_ADDR);
    endfunction

endpackage

// File: rtl/oam_dma_seq.sv
// OAM DMA sequencer: halt, optional odd-cycle alignment (OAM_DMA_ALIGN_EN),
// then DMA_LEN read/write pairs from page {page,cnt} into OAMDATA.
module oam_dma_seq
    import cpu_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic [7:0]  trigger_page,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_rw_n,
    output logic        dma_en
);

    dma_state_t       state;
    dma_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       page;
    logic             last_byte;

    assign last_byte = (cnt == CNT_W'(DMA_LEN - 1));

`ifdef OAM_DMA_ALIGN_EN
    // Free-running CPU cycle parity; an odd halt cycle costs one alignment cycle.
    logic parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            page  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && trigger) begin
                page <= trigger_page;
            end
            if (state == DMA_WR) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        dma_active = 1'b1;
        dma_addr   = 16'h0000;
        dma_rw_n   = 1'b1;
        dma_en     = 1'b0;
        case (state)
            IDLE: begin
                dma_active = 1'b0;
                if (trigger) begin
                    state_next = DMA_HALT;
                end
            end
            DMA_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                state_next = parity ? DMA_ALIGN : DMA_RD;
`else
                state_next = DMA_RD;
`endif
            end
            DMA_ALIGN: begin
                state_next = DMA_RD;
            end
            DMA_RD: begin
                dma_addr   = {page, cnt};
                dma_en     = 1'b1;
                state_next = DMA_WR;
            end
            DMA_WR: begin
                dma_addr   = OAMDATA_ADDR;
                dma_rw_n   = 1'b0;
                dma_en     = 1'b1;
                state_next = last_byte ? IDLE : DMA_RD;
            end
            default: begin
                dma_active = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// CPU memory bus arbiter: execute-over-fetch priority plus OAM DMA takeover.
// Define OAM_DMA_ALIGN_EN to enable the odd-parity DMA alignment cycle.
module cpu_mem_arbiter
    import cpu_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    input  logic        e_req,
    input  logic [15:0] e_addr,
    input  logic        e_rw_n,
    input  logic [7:0]  e_wdata,
    output logic        e_gnt,
    output logic        e_rvalid,
    input  logic [7:0]  mem_data_in,
    output logic [15:0] addr_bus,
    output logic [7:0]  mem_data_out,
    output logic        rw_n,
    output logic        memory_access,
    output logic        cpu_halt,
    output logic        dma_active
);

    bus_owner_t  owner;
    logic        dma_trigger;
    logic [15:0] dma_addr;
    logic        dma_rw_n;
    logic        dma_en;

    // Reset parks the bus; otherwise DMA beats execute beats fetch.
    always_comb begin
        owner = OWN_NONE;
        if (rst) begin
            owner = OWN_NONE;
        end else if (dma_active) begin
            owner = OWN_DMA;
        end else if (e_req) begin
            owner = OWN_E;
        end else if (f_req) begin
            owner = OWN_F;
        end
    end

    assign f_gnt       = (owner == OWN_F);
    assign e_gnt       = (owner == OWN_E);
    assign cpu_halt    = dma_active;
    assign dma_trigger = is_dma_trigger(e_gnt, e_rw_n, e_addr);

    oam_dma_seq u_dma (
        .clk          (clk),
        .rst          (rst),
        .trigger      (dma_trigger),
        .trigger_page (e_wdata),
        .dma_active   (dma_active),
        .dma_addr     (dma_addr),
        .dma_rw_n     (dma_rw_n),
        .dma_en       (dma_en)
    );

    always_comb begin
        addr_bus      = 16'h0000;
        mem_data_out  = 8'h00;
        rw_n          = 1'b1;
        memory_access = 1'b0;
        case (owner)
            OWN_F: begin
                addr_bus      = f_addr;
                memory_access = 1'b1;
            end
            OWN_E: begin
                addr_bus      = e_addr;
                rw_n          = e_rw_n;
                mem_data_out  = e_wdata;
                memory_access = 1'b1;
            end
            OWN_DMA: begin
                addr_bus      = dma_addr;
                rw_n          = dma_rw_n;
                mem_data_out  = dma_rw_n ? 8'h00 : mem_data_in;
                memory_access = dma_en;
            end
            default: begin
                memory_access = 1'b0;
            end
        endcase
    end

    // Synchronous memory returns data one cycle after a granted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_rvalid <= 1'b0;
            e_rvalid <= 1'b0;
        end else begin
            f_rvalid <= f_gnt;
            e_rvalid <= e_gnt & e_rw_n;
        end
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Owns the single CPU memory bus (addr_bus / mem_data_out / rw_n / memory_access).
- Shares the bus between the fetch stage and the execute stage.
- Runs the NES OAM DMA sequence, triggered by an execute-stage write to $4014.
- While DMA is active, asserts cpu_halt to stall fetch, decode and execute.

Parameters:
- OAM_DMA_ADDR, 16'h4014, execute write address that triggers OAM DMA.
- OAMDATA_ADDR, 16'h2004, PPU OAMDATA port, the DMA write target.
- DMA_LEN, 256, bytes per DMA; the byte counter is $clog2(DMA_LEN) bits.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch read request; held until f_gnt.
- f_addr  in  16  fetch address.
- f_gnt  out  1  fetch owns the bus this cycle.
- f_rvalid  out  1  mem_data_in belongs to fetch this cycle.
- e_req  in  1  execute request; held until e_gnt.
- e_addr  in  16  execute address.
- e_rw_n  in  1  1 = read, 0 = write.
- e_wdata  in  8  execute write data.
- e_gnt  out  1  execute owns the bus this cycle.
- e_rvalid  out  1  mem_data_in belongs to execute this cycle.
- mem_data_in  in  8  memory read data, valid the cycle after the address.
- addr_bus  out  16  memory address.
- mem_data_out  out  8  memory write data.
- rw_n  out  1  1 = read, 0 = write.
- memory_access  out  1  bus cycle valid.
- cpu_halt  out  1  pipeline stall during DMA.
- dma_active  out  1  DMA state machine not IDLE.

Behaviour:
- Bus outputs are a combinational mux of the current owner. All state is registered.
- Memory is synchronous: the address is sampled at the clock edge and data appears on mem_data_in in the next cycle.
- Reset (takes priority over everything, including mid-DMA):
  - state = IDLE, byte counter 0, parity 0, page 0.
  - f_rvalid, e_rvalid, cpu_halt and dma_active are 0.
  - The bus shows addr 0, data 0, rw_n = 1, memory_access = 0.
- States: IDLE, DMA_HALT, DMA_ALIGN, DMA_RD, DMA_WR.
- IDLE arbitration:
  - Priority: execute over fetch.
  - e_gnt = e_req. f_gnt = f_req & ~e_req.
  - The winner drives the bus; memory_access = 1.
  - Fetch is always rw_n = 1.
  - With no request: memory_access = 0, rw_n = 1.
- Read data valid:
  - f_rvalid / e_rvalid = registered (gnt & read) of the previous cycle.
  - Exactly one is high at a time.
  - Both are 0 in any cycle that follows a DMA cycle.
- DMA trigger:
  - Condition: e_gnt & ~e_rw_n & e_addr == OAM_DMA_ADDR.
  - The trigger write itself still goes to the bus.
  - page <= e_wdata; next state = DMA_HALT.
- DMA_HALT (1 cycle):
  - cpu_halt = 1, memory_access = 0.
  - Next state is DMA_ALIGN if parity == 1, else DMA_RD.
- DMA_ALIGN (1 cycle): idle bus, next state DMA_RD.
- DMA_RD:
  - addr = {page, cnt}, rw_n = 1, memory_access = 1.
  - Next state DMA_WR.
- DMA_WR:
  - addr = OAMDATA_ADDR, rw_n = 0, mem_data_out = mem_data_in (passthrough), memory_access = 1.
  - cnt <= cnt + 1.
  - Next state is IDLE if cnt == DMA_LEN-1, else DMA_RD.
  - The counter wraps to 0.
- Parity: toggles every clock from reset; it is evaluated in the DMA_HALT cycle.
- DMA duration: 513 cycles (even parity) or 514 (odd parity), counted from the cycle after the trigger.
- In all DMA states:
  - cpu_halt = 1, dma_active = 1, f_gnt = e_gnt = 0.
  - Pending requests are not lost; they are granted in the first IDLE cycle.
- cpu_halt deasserts in the first cycle after the last DMA_WR.
- Writes to OAM_DMA_ADDR that arrive during DMA cannot occur, because no grant is given.
- A read of OAM_DMA_ADDR is a plain read; it does not trigger DMA.

Optional Feature:
- Macro: OAM_DMA_ALIGN_EN.
- Defined: odd-parity alignment cycle as above, giving 513/514 cycles.
- Undefined: DMA_ALIGN is never entered (DMA_HALT always goes to DMA_RD), giving a constant 513 cycles. The parity register may be removed.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - state enum (IDLE, DMA_HALT, DMA_ALIGN, DMA_RD, DMA_WR);
  - OAM_DMA_ADDR / OAMDATA_ADDR constants;
  - bus owner encoding (OWN_NONE, OWN_F, OWN_E, OWN_DMA).
- One natural sub-module: oam_dma_seq.
  - Contains the state machine, counter, page and parity.
  - Outputs dma_active, dma_addr, dma_rw_n and dma_en.
- The top level keeps the priority mux and the rvalid registers.

Test Plan:
- f_req=1 @ $8000 with e_req=0 -> f_gnt=1, addr_bus=$8000, rw_n=1; f_rvalid=1 next cycle with mem_data_in forwarded.
- f_req and e_req (read $0010) in the same cycle -> e_gnt=1, f_gnt=0, addr=$0010; fetch granted in the next cycle.
- e write $02 to $4014 at even parity -> 256 RD/WR pairs: RD $0200-$02FF, WR $2004 with the read data; cpu_halt high exactly 513 cycles.
- Same trigger at odd parity -> one DMA_ALIGN idle cycle; cpu_halt high 514 cycles (513 with OAM_DMA_ALIGN_EN undefined).
- rst=1 asserted during DMA_WR of byte 100 -> next cycle state IDLE, cpu_halt=0, memory_access=0; a new trigger restarts at byte 0.
- f_req held throughout DMA -> f_gnt=0 during DMA; f_gnt=1 in the first cycle after cpu_halt falls; no spurious rvalid during DMA.
